// File: rtl/seq_sort_engine.sv
// Streaming insertion sorter: (char, weight) pairs sorted on arrival, one per cycle, then streamed out.
// Optional macro SORT_PAR_OUT_EN adds the whole sorted batch on parallel buses during OUT.
module seq_sort_slot #(
  parameter int CHAR_W   = 4,
  parameter int WEIGHT_W = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_we,
  input  logic                i_occ,
  input  logic                i_desc,
  input  logic                i_prec_prev,
  input  logic [CHAR_W-1:0]   i_new_char,
  input  logic [WEIGHT_W-1:0] i_new_wt,
  input  logic [CHAR_W-1:0]   i_prev_char,
  input  logic [WEIGHT_W-1:0] i_prev_wt,
  output logic                o_prec,
  output logic [CHAR_W-1:0]   o_char,
  output logic [WEIGHT_W-1:0] o_wt
);
  logic [CHAR_W-1:0]   r_char;
  logic [WEIGHT_W-1:0] r_wt;

  // Ties count as preceding, so equal weights keep arrival order in both modes.
  assign o_prec = i_occ & (i_desc ? (r_wt >= i_new_wt) : (r_wt <= i_new_wt));
  assign o_char = r_char;
  assign o_wt   = r_wt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_char <= '0;
      r_wt   <= '0;
    end else if (i_we && !o_prec) begin
      r_char <= i_prec_prev ? i_new_char : i_prev_char;
      r_wt   <= i_prec_prev ? i_new_wt   : i_prev_wt;
    end
  end
endmodule

module seq_sort_engine #(
  parameter int DEPTH    = 8,
  parameter int CHAR_W   = 4,
  parameter int WEIGHT_W = 5,
  localparam int RANK_W  = ($clog2(DEPTH) < 1) ? 1 : $clog2(DEPTH),
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CHAR_W-1:0]   in_char,
  input  logic [WEIGHT_W-1:0] in_weight,
  input  logic                in_last,
  input  logic                in_desc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CHAR_W-1:0]   out_char,
  output logic [WEIGHT_W-1:0] out_weight,
  output logic [RANK_W-1:0]   out_rank,
`ifdef SORT_PAR_OUT_EN
  output logic [DEPTH*CHAR_W-1:0]   out_char_all,
  output logic [DEPTH*WEIGHT_W-1:0] out_weight_all,
  output logic [CNT_W-1:0]          out_count,
`endif
  output logic                out_last
);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_OUT} state_t;
  state_t r_state, w_nstate;

  logic [CNT_W-1:0]  r_cnt;
  logic [RANK_W-1:0] r_rp;
  logic              r_desc, r_in_rdy;
  logic              w_acc, w_desc, w_out, w_olast, w_unused_prec;

  logic [DEPTH-1:0]                w_prec, w_occ, w_prev_prec;
  logic [DEPTH-1:0][CHAR_W-1:0]    w_char, w_prev_char;
  logic [DEPTH-1:0][WEIGHT_W-1:0]  w_wt, w_prev_wt;

  assign w_acc   = in_valid & r_in_rdy;
  assign w_desc  = (r_state == S_IDLE) ? in_desc : r_desc;
  assign w_out   = (r_state == S_OUT);
  assign w_olast = ((CNT_W'(r_rp) + CNT_W'(1)) == r_cnt);
  assign w_unused_prec = w_prec[DEPTH-1];

  // Stored entries stay sorted, so the preceding set is a prefix; the first
  // non-preceding slot takes the new item and the rest shift up by one.
  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    assign w_occ[g] = (CNT_W'(g) < r_cnt);
    if (g == 0) begin : g_first
      assign w_prev_prec[g] = 1'b1;
      assign w_prev_char[g] = '0;
      assign w_prev_wt[g]   = '0;
    end else begin : g_rest
      assign w_prev_prec[g] = w_prec[g-1];
      assign w_prev_char[g] = w_char[g-1];
      assign w_prev_wt[g]   = w_wt[g-1];
    end
    seq_sort_slot #(.CHAR_W(CHAR_W), .WEIGHT_W(WEIGHT_W)) u_slot (
      .clk(clk), .rst_n(rst_n), .i_we(w_acc), .i_occ(w_occ[g]), .i_desc(w_desc),
      .i_prec_prev(w_prev_prec[g]), .i_new_char(in_char), .i_new_wt(in_weight),
      .i_prev_char(w_prev_char[g]), .i_prev_wt(w_prev_wt[g]),
      .o_prec(w_prec[g]), .o_char(w_char[g]), .o_wt(w_wt[g])
    );
`ifdef SORT_PAR_OUT_EN
    assign out_char_all[CHAR_W*g +: CHAR_W]       = (w_out && w_occ[g]) ? w_char[g] : '0;
    assign out_weight_all[WEIGHT_W*g +: WEIGHT_W] = (w_out && w_occ[g]) ? w_wt[g]   : '0;
`endif
  end

`ifdef SORT_PAR_OUT_EN
  assign out_count = w_out ? r_cnt : '0;
`endif

  always_comb begin
    w_nstate = r_state;
    case (r_state)
      S_IDLE: if (w_acc) w_nstate = in_last ? S_OUT : S_LOAD;
      S_LOAD: if (w_acc && (in_last || r_cnt == CNT_W'(DEPTH - 1))) w_nstate = S_OUT;
      S_OUT:  if (out_ready && w_olast) w_nstate = S_IDLE;
      default: w_nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nstate;
  end

  // in_ready is registered so it stays low during reset and rises on the first edge after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_rp     <= '0;
      r_desc   <= 1'b0;
      r_in_rdy <= 1'b0;
    end else begin
      r_in_rdy <= (w_nstate != S_OUT);
      if (w_acc) r_cnt <= r_cnt + CNT_W'(1);
      if (w_acc && r_state == S_IDLE) r_desc <= in_desc;
      if (w_out && out_ready) begin
        if (w_olast) begin
          r_cnt <= '0;
          r_rp  <= '0;
        end else begin
          r_rp <= r_rp + RANK_W'(1);
        end
      end
    end
  end

  assign in_ready   = r_in_rdy;
  assign out_valid  = w_out;
  assign out_char   = w_out ? w_char[r_rp] : '0;
  assign out_weight = w_out ? w_wt[r_rp]   : '0;
  assign out_rank   = w_out ? r_rp         : '0;
  assign out_last   = w_out & w_olast;
endmodule

// File: tb/tb_seq_sort_engine.sv
// Randomised bench for seq_sort_engine: rank-counting reference model, per-cycle compare, literal batches.
module tb_seq_sort_engine;
  localparam int DEPTH = 8, CW = 4, WW = 5, RW = 3, NW = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 0, in_last = 0, in_desc = 0, out_ready = 1;
  logic [CW-1:0] in_char = '0;
  logic [WW-1:0] in_weight = '0;
  logic in_ready, out_valid, out_last;
  logic [CW-1:0] out_char;
  logic [WW-1:0] out_weight;
  logic [RW-1:0] out_rank;
`ifdef SORT_PAR_OUT_EN
  logic [DEPTH*CW-1:0] out_char_all;
  logic [DEPTH*WW-1:0] out_weight_all;
  logic [NW-1:0]       out_count;
`endif

  seq_sort_engine #(.DEPTH(DEPTH), .CHAR_W(CW), .WEIGHT_W(WW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_char(in_char), .in_weight(in_weight), .in_last(in_last), .in_desc(in_desc),
    .out_valid(out_valid), .out_ready(out_ready), .out_char(out_char),
    .out_weight(out_weight), .out_rank(out_rank),
`ifdef SORT_PAR_OUT_EN
    .out_char_all(out_char_all), .out_weight_all(out_weight_all), .out_count(out_count),
`endif
    .out_last(out_last)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model: items collected in arrival order; ranks computed by counting.
  bit m_out = 0, m_rdy = 0, m_desc = 0;
  int m_n = 0, m_rp = 0;
  int m_ic[DEPTH], m_iw[DEPTH], m_sc[DEPTH], m_sw[DEPTH];
  int cap_c[$], cap_w[$], cap_r[$], cap_l[$];
  int or_rand = 0, bp_left = 0;

  function automatic void model_sort();
    for (int j = 0; j < m_n; j++) begin
      int r = 0;
      for (int k = 0; k < m_n; k++) begin
        if (m_desc ? (m_iw[k] > m_iw[j]) : (m_iw[k] < m_iw[j])) r++;
        else if (m_iw[k] == m_iw[j] && k < j) r++;
      end
      m_sc[r] = m_ic[j];
      m_sw[r] = m_iw[j];
    end
  endfunction

  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      m_out = 0; m_rdy = 0; m_n = 0; m_rp = 0;
    end else begin
      if (!m_out) begin
        if (in_valid && m_rdy) begin
          if (m_n == 0) m_desc = in_desc;
          m_ic[m_n] = int'(in_char);
          m_iw[m_n] = int'(in_weight);
          m_n++;
          if (in_last || m_n == DEPTH) begin
            model_sort();
            m_out = 1; m_rp = 0;
          end
        end
      end else if (out_ready) begin
        if (m_rp == m_n - 1) begin m_out = 0; m_n = 0; m_rp = 0; end
        else m_rp++;
      end
      m_rdy = !m_out;
    end
  end

  initial forever begin
    @(negedge clk); #1;
    if (!rst_n) begin
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
    end else begin
      chk("in_ready", in_ready, m_rdy);
      chk("out_valid", out_valid, m_out);
      chk("out_char", out_char, m_out ? m_sc[m_rp] : 0);
      chk("out_weight", out_weight, m_out ? m_sw[m_rp] : 0);
      chk("out_rank", out_rank, m_out ? m_rp : 0);
      chk("out_last", out_last, m_out && (m_rp == m_n - 1));
`ifdef SORT_PAR_OUT_EN
      chk("out_count", out_count, m_out ? m_n : 0);
      for (int i = 0; i < DEPTH; i++) begin
        chk("char_all", out_char_all[CW*i +: CW], (m_out && i < m_n) ? m_sc[i] : 0);
        chk("weight_all", out_weight_all[WW*i +: WW], (m_out && i < m_n) ? m_sw[i] : 0);
      end
`endif
      if (out_valid && out_ready) begin
        cap_c.push_back(int'(out_char)); cap_w.push_back(int'(out_weight));
        cap_r.push_back(int'(out_rank)); cap_l.push_back(int'(out_last));
      end
    end
  end

  // out_ready: stall 5 cycles at rank 2 when armed, otherwise random or always high.
  initial forever begin
    @(negedge clk);
    if (bp_left > 0 && out_valid && out_rank == 2) begin
      out_ready = 0; bp_left--;
    end else out_ready = or_rand ? ($urandom_range(0, 99) < 70) : 1'b1;
  end

  task automatic push(input int c, input int w, input bit last, input bit desc, input int gap);
    bit done = 0;
    int t = 0;
    while (!done) begin
      @(negedge clk);
      t++;
      if (t > 200) begin chk("push_timeout", 0, 1); return; end
      if ($urandom_range(0, 99) < gap) in_valid = 0;
      else begin
        in_valid = 1; in_char = CW'(c); in_weight = WW'(w); in_last = last; in_desc = desc;
        done = in_ready;
      end
    end
  endtask

  task automatic drain(input bit noise);
    int t;
    for (t = 0; t < 400; t++) begin
      @(negedge clk);
      if (in_ready) break;
      in_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      in_last = 1'($urandom_range(0, 1));
      in_char = CW'($urandom); in_weight = WW'($urandom);
    end
    in_valid = 0;
    if (t == 400) chk("drain_timeout", 0, 1);
  endtask

  int b_c[DEPTH], b_w[DEPTH];
  task automatic batch(input int n, input bit desc, input bit use_last, input int gap, input bit noise);
    for (int i = 0; i < n; i++)
      push(b_c[i], b_w[i], use_last && i == n - 1, (i == 0) ? desc : 1'($urandom_range(0, 1)), gap);
    drain(noise);
  endtask

  task automatic chk_cap(input string nm, input int n, input int ec[DEPTH], input int ew[DEPTH]);
    chk({nm, "_len"}, cap_c.size(), n);
    for (int i = 0; i < n && i < cap_c.size(); i++) begin
      chk({nm, "_char"}, cap_c[i], ec[i]);
      chk({nm, "_weight"}, cap_w[i], ew[i]);
      chk({nm, "_rank"}, cap_r[i], i);
      chk({nm, "_last"}, cap_l[i], i == n - 1);
    end
  endtask

  task automatic clr_cap();
    cap_c.delete(); cap_w.delete(); cap_r.delete(); cap_l.delete();
  endtask

  task automatic reset_pulse();
    @(negedge clk); #3;
    rst_n = 0; #1;
    chk("arst_in_ready", in_ready, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_char", out_char, 0);
    chk("arst_out_weight", out_weight, 0);
    chk("arst_out_rank", out_rank, 0);
    chk("arst_out_last", out_last, 0);
    in_valid = 0;
    @(negedge clk); #3;
    rst_n = 1;
  endtask

  int a_c[DEPTH] = '{6, 3, 7, 1, 5, 0, 2, 4};
  int a_w[DEPTH] = '{0, 1, 2, 3, 3, 5, 5, 7};
  int d_c[DEPTH] = '{4, 0, 2, 1, 5, 7, 3, 6};
  int d_w[DEPTH] = '{7, 5, 5, 3, 3, 2, 1, 0};
  int e_c[DEPTH], e_w[DEPTH];

  initial begin
    repeat (2) @(negedge clk);
    #3 rst_n = 1;

    b_c = '{0, 1, 2, 3, 4, 5, 6, 7};
    b_w = '{5, 3, 5, 1, 7, 3, 0, 2};
    clr_cap(); batch(8, 0, 1, 0, 0); chk_cap("asc", 8, a_c, a_w);
    clr_cap(); batch(8, 1, 1, 0, 0); chk_cap("desc", 8, d_c, d_w);

    b_c[0:2] = '{10, 11, 12}; b_w[0:2] = '{9, 9, 2};
    e_c = '{12, 10, 11, 0, 0, 0, 0, 0}; e_w = '{2, 9, 9, 0, 0, 0, 0, 0};
    clr_cap(); batch(3, 0, 1, 0, 0); chk_cap("short", 3, e_c, e_w);

    b_c = '{0, 1, 2, 3, 4, 5, 6, 7};
    b_w = '{5, 3, 5, 1, 7, 3, 0, 2};
    clr_cap();
    for (int i = 0; i < DEPTH; i++) push(b_c[i], b_w[i], 0, 0, 0);
    @(negedge clk); #1;
    chk("auto_close_in_ready", in_ready, 0);
    drain(0); chk_cap("auto", 8, a_c, a_w);

    bp_left = 5;
    clr_cap(); batch(8, 0, 1, 0, 1); chk_cap("bp", 8, a_c, a_w);
    chk("bp_consumed", bp_left, 0);

    b_c[0] = 9; b_w[0] = 31;
    e_c = '{9, 0, 0, 0, 0, 0, 0, 0}; e_w = '{31, 0, 0, 0, 0, 0, 0, 0};
    clr_cap(); batch(1, 1, 1, 0, 0); chk_cap("single", 1, e_c, e_w);

    b_c = '{0, 1, 2, 3, 4, 5, 6, 7};
    b_w = '{31, 30, 29, 28, 27, 26, 25, 24};
    for (int i = 0; i < 4; i++) push(b_c[i], b_w[i], 0, 0, 0);
    reset_pulse();
    b_c[0:2] = '{1, 2, 3}; b_w[0:2] = '{0, 31, 16};
    e_c = '{1, 3, 2, 0, 0, 0, 0, 0}; e_w = '{0, 16, 31, 0, 0, 0, 0, 0};
    clr_cap(); batch(3, 0, 1, 0, 0); chk_cap("post_rst_load", 3, e_c, e_w);

    b_c = '{0, 1, 2, 3, 4, 5, 6, 7};
    b_w = '{5, 3, 5, 1, 7, 3, 0, 2};
    for (int i = 0; i < DEPTH; i++) push(b_c[i], b_w[i], i == DEPTH - 1, 1, 0);
    @(negedge clk); in_valid = 0;
    @(negedge clk);
    reset_pulse();
    b_c[0:4] = '{8, 9, 10, 11, 12}; b_w[0:4] = '{0, 31, 0, 31, 15};
    e_c = '{9, 11, 12, 8, 10, 0, 0, 0}; e_w = '{31, 31, 15, 0, 0, 0, 0, 0};
    clr_cap(); batch(5, 1, 1, 0, 0); chk_cap("post_rst_out", 5, e_c, e_w);

    or_rand = 1;
    for (int b = 0; b < 40; b++) begin
      int n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) begin
        int sel = $urandom_range(0, 3);
        b_c[i] = $urandom_range(0, 15);
        b_w[i] = (sel == 0) ? 0 : (sel == 1) ? 31 : (sel == 2) ? $urandom_range(0, 3) : $urandom_range(0, 31);
      end
      batch(n, 1'($urandom_range(0, 1)), (n < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1)), 25, 1);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_sort_engine.md
Name: seq_sort_engine

Overview:
- Streaming, parametrised weight sorter; successor to the combinational 8-entry character/weight sort used in the Huffman datapath.
- Accepts 1..DEPTH (character, weight) pairs serially over a valid/ready handshake and insertion-sorts them on arrival, one item per cycle.
- Streams the items back out in sorted order with backpressure.
- Supports a stable ascending or descending mode, selected per batch.

Parameters:
- DEPTH, 8, maximum items per batch (>=2).
- CHAR_W, 4, character field width.
- WEIGHT_W, 5, weight field width (unsigned).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; asynchronous, active-low.
- in_valid  input  1  input item present.
- in_ready  output  1  engine can accept an item.
- in_char  input  CHAR_W  item character.
- in_weight  input  WEIGHT_W  item weight.
- in_last  input  1  marks the final item of the batch.
- in_desc  input  1  sort order: 0 = ascending, 1 = descending; sampled on the first item only.
- out_valid  output  1  sorted item present.
- out_ready  input  1  downstream accepts the item.
- out_char  output  CHAR_W  sorted character.
- out_weight  output  WEIGHT_W  sorted weight.
- out_rank  output  max(1,$clog2(DEPTH))  position of the item in the sorted order (0 first).
- out_last  output  1  marks the final sorted item.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - Item count and storage cleared.
  - Outputs: in_ready=0 while in reset; every other output = 0.
  - in_ready=1 from the first clk edge after release.
- States:
  - IDLE: in_ready=1, out_valid=0. An accepted item writes slot 0, latches in_desc, count=1. Go to LOAD, or to OUT if in_last=1.
  - LOAD: in_ready=1. Each accept (in_valid&in_ready) inserts the new item in a single cycle, and count increments.
    - Insertion position p = number of stored entries that precede the new item. In ascending mode an entry precedes if its weight <= new weight; in descending mode if its weight >= new weight.
    - Entries at positions >= p shift up by one.
    - Ties therefore keep arrival order (stable) in both modes.
    - If the accept carries in_last=1, or the count reaches DEPTH, go to OUT next cycle.
    - A full batch ends automatically; in_last on the DEPTH-th item is redundant but legal.
  - OUT: in_ready=0, out_valid=1.
    - Outputs are driven from a read pointer rp (initially 0): out_char/out_weight = slot[rp], out_rank=rp, out_last = (rp==count-1).
    - On out_valid&out_ready, rp increments.
    - On the handshake with out_last, go to IDLE, clear count and rp, and deassert out_valid the next cycle.
- Latency:
  - Last input accept at edge t gives out_valid=1 after t, with the first sorted item.
  - A batch of N items takes N cycles in and at least N cycles out.
  - in_ready returns 1 the cycle after the final output handshake.
- Backpressure: when out_ready=0, all out_* signals hold stable.
- Boundaries:
  - in_valid during OUT is ignored.
  - A single-item batch (in_last on first accept) emits one item with out_last=1, rank 0.
  - in_desc changing mid-batch has no effect.
  - Weights 0 and 2^WEIGHT_W-1 sort correctly; comparison is unsigned.
  - rst_n low at any point (mid-LOAD or mid-OUT) discards the batch immediately.

Optional Feature:
- Macro: SORT_PAR_OUT_EN.
- Defined:
  - Extra outputs: out_char_all (DEPTH*CHAR_W), out_weight_all (DEPTH*WEIGHT_W), out_count ($clog2(DEPTH+1)).
  - Slice i (bits [CHAR_W*i +: CHAR_W] and likewise for weight) = sorted slot i.
  - Slots >= count read 0.
  - These outputs are valid and stable for the whole OUT state and 0 otherwise.
  - out_count = count in OUT, 0 otherwise.
- Undefined: these ports and their logic do not exist; serial behaviour is identical.

Test Plan:
- Ascending, DEPTH=8, back-to-back input:
  - Stimulus: chars 0..7 with weights 5,3,5,1,7,3,0,2; in_last on item 8; out_ready=1.
  - Required: weights 0,1,2,3,3,5,5,7; chars 6,3,7,1,5,0,2,4; ranks 0..7; out_last only on rank 7; out_valid rises the cycle after the last accept.
- Descending, same input with in_desc=1:
  - Required: weights 7,5,5,3,3,2,1,0; chars 4,0,2,1,5,7,3,6.
- Short batch and auto-terminate:
  - Stimulus: 3 items, weights 9,9,2, chars A,B,C, in_last on item 3.
  - Required: order C,A,B; out_last on rank 2.
  - Stimulus: 8 items with no in_last.
  - Required: batch closes automatically; in_ready=0 after the 8th accept.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles at rank 2.
  - Required: out_* unchanged over those cycles; no item lost or duplicated; in_valid pulses during OUT are not accepted.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 asynchronously mid-LOAD (after 4 items) and again mid-OUT.
  - Required: all outputs 0 immediately; the next batch sorts correctly with no residue.
- SORT_PAR_OUT_EN build, 5-item batch:
  - Required: out_count=5; slices 0..4 sorted, slices 5..7 = 0; all bus outputs 0 back in IDLE.
